sliding_window_kxk: RTL and testbench

- Parametrised streaming K×K window generator for the convolution datapath; successor to the fixed 3×3 / stride-1 window block.
- Consumes a raster-order pixel stream, buffers K-1 image rows, and presents a full K×K window on a packed bus.
- Supports configurable kernel size, stride, frame resync and an explicit last-window flag, so the conv engine and pooling stages can share one window source.

---
 rtl/sliding_window_kxk.sv | 185 ++++++++++++++++++
 tb/tb_sliding_window_kxk.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sliding_window_kxk.sv
// Streaming KxK window generator: K-1 circular line buffers feed a KxK shift
// array; windows are emitted on the stride grid with a last-window flag.
// Optional macro SLIDING_WINDOW_POS_EN adds output-map coordinates per window.
module sliding_window_kxk #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_WIDTH  = 220,
  parameter int unsigned IMG_HEIGHT = 220,
  parameter int unsigned K          = 3,
  parameter int unsigned STRIDE     = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          valid_in,
  input  logic                          sof_in,
  output logic [K*K*DATA_WIDTH-1:0]     window_out,
  output logic                          valid_out,
  output logic                          last_out
`ifdef SLIDING_WINDOW_POS_EN
  ,
  output logic [$clog2(IMG_WIDTH)-1:0]  win_col_out,
  output logic [$clog2(IMG_HEIGHT)-1:0] win_row_out
`endif
);

  localparam int unsigned DW       = DATA_WIDTH;
  localparam int unsigned CW       = $clog2(IMG_WIDTH);
  localparam int unsigned RW       = $clog2(IMG_HEIGHT);
  localparam int unsigned PW       = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int unsigned NB       = K - 1;
  localparam int unsigned LAST_COL = (K - 1) + ((IMG_WIDTH - K) / STRIDE) * STRIDE;
  localparam int unsigned LAST_ROW = (K - 1) + ((IMG_HEIGHT - K) / STRIDE) * STRIDE;

  logic [CW-1:0]       in_col_q, in_col_d;
  logic [RW-1:0]       in_row_q, in_row_d;
  logic [PW-1:0]       col_ph_q, col_ph_d;
  logic [PW-1:0]       row_ph_q, row_ph_d;

  logic [DW-1:0]       lb_mem [NB][IMG_WIDTH];
  logic [DW-1:0]       lb_rd  [NB];
  logic [DW-1:0]       win_q  [K][K];
  logic [DW-1:0]       win_d  [K][K];
  logic [K*K*DW-1:0]   win_flat_c;
  logic [K*K*DW-1:0]   window_q;
  logic                valid_q;
  logic                last_q;

  logic [CW-1:0]       col_c;
  logic [RW-1:0]       row_c;
  logic [PW-1:0]       cph_c, rph_c, cph_inc_c, rph_inc_c;
  logic                col_wrap_c, row_wrap_c;
  logic                emit_c, last_c;

  assign window_out = window_q;
  assign valid_out  = valid_q;
  assign last_out   = last_q;

  // Effective position of the incoming pixel (sof forces it to the origin)
  always_comb begin
    col_c      = sof_in ? '0 : in_col_q;
    row_c      = sof_in ? '0 : in_row_q;
    cph_c      = (col_c <= CW'(K - 1)) ? '0 : col_ph_q;
    rph_c      = (row_c <= RW'(K - 1)) ? '0 : row_ph_q;
    cph_inc_c  = (cph_c == PW'(STRIDE - 1)) ? '0 : cph_c + PW'(1);
    rph_inc_c  = (rph_c == PW'(STRIDE - 1)) ? '0 : rph_c + PW'(1);
    col_wrap_c = (col_c == CW'(IMG_WIDTH - 1));
    row_wrap_c = (row_c == RW'(IMG_HEIGHT - 1));
    emit_c     = valid_in && (row_c >= RW'(K - 1)) && (col_c >= CW'(K - 1)) &&
                 (cph_c == '0) && (rph_c == '0);
    last_c     = emit_c && (col_c == CW'(LAST_COL)) && (row_c == RW'(LAST_ROW));
  end

  // Next raster position and stride phases
  always_comb begin
    in_col_d = in_col_q;
    in_row_d = in_row_q;
    col_ph_d = col_ph_q;
    row_ph_d = row_ph_q;
    if (valid_in) begin
      in_col_d = col_wrap_c ? '0 : col_c + CW'(1);
      col_ph_d = (col_c >= CW'(K - 1)) ? cph_inc_c : '0;
      in_row_d = row_c;
      row_ph_d = rph_c;
      if (col_wrap_c) begin
        in_row_d = row_wrap_c ? '0 : row_c + RW'(1);
        row_ph_d = (row_c >= RW'(K - 1)) ? rph_inc_c : '0;
      end
    end
  end

  // Line-buffer read port and shifted window with its new rightmost column
  always_comb begin
    for (int i = 0; i < int'(NB); i++) begin
      lb_rd[i] = lb_mem[i][col_c];
    end
    win_d = win_q;
    for (int r = 0; r < int'(K); r++) begin
      for (int c = 0; c < int'(K) - 1; c++) begin
        win_d[r][c] = win_q[r][c+1];
      end
    end
    for (int r = 0; r < int'(NB); r++) begin
      win_d[r][K-1] = lb_rd[r];
    end
    win_d[K-1][K-1] = data_in;
    win_flat_c = '0;
    for (int r = 0; r < int'(K); r++) begin
      for (int c = 0; c < int'(K); c++) begin
        win_flat_c[(r*K+c)*DW +: DW] = win_d[r][c];
      end
    end
  end

  // Line buffers: each row slot takes the word of the row below it
  always_ff @(posedge clk) begin
    if (valid_in) begin
      for (int i = 0; i < int'(NB) - 1; i++) begin
        lb_mem[i][col_c] <= lb_rd[i+1];
      end
      lb_mem[NB-1][col_c] <= data_in;
    end
  end

  // Counters, window shift array and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      in_col_q <= '0;
      in_row_q <= '0;
      col_ph_q <= '0;
      row_ph_q <= '0;
      window_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      for (int r = 0; r < int'(K); r++) begin
        for (int c = 0; c < int'(K); c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      in_col_q <= in_col_d;
      in_row_q <= in_row_d;
      col_ph_q <= col_ph_d;
      row_ph_q <= row_ph_d;
      valid_q  <= emit_c;
      last_q   <= last_c;
      if (valid_in) begin
        win_q <= win_d;
      end
      if (emit_c) begin
        window_q <= win_flat_c;
      end
    end
  end

`ifdef SLIDING_WINDOW_POS_EN
  logic [CW-1:0] oc_q, win_col_q;
  logic [RW-1:0] or_q, win_row_q;

  assign win_col_out = win_col_q;
  assign win_row_out = win_row_q;

  // Output-map coordinate counters advanced on each emitted window
  always_ff @(posedge clk) begin
    if (rst) begin
      oc_q      <= '0;
      or_q      <= '0;
      win_col_q <= '0;
      win_row_q <= '0;
    end else if (valid_in && sof_in) begin
      oc_q <= '0;
      or_q <= '0;
    end else if (emit_c) begin
      win_col_q <= oc_q;
      win_row_q <= or_q;
      if (col_c == CW'(LAST_COL)) begin
        oc_q <= '0;
        or_q <= (row_c == RW'(LAST_ROW)) ? '0 : or_q + RW'(1);
      end else begin
        oc_q <= oc_q + CW'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_sliding_window_kxk.sv
// Bench for sliding_window_kxk: two 8x8 K=3 instances (stride 1 and stride 2)
// share one raster stream; a scoreboard checks every window pulse.
module tb_sliding_window_kxk;

  typedef struct {
    logic [71:0] win;
    bit          last;
    int          pc;
    int          pr;
    int          tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic        valid_in;
  logic        sof_in;
  logic [71:0] w1, w2;
  logic        v1, v2, l1, l2;
`ifdef SLIDING_WINDOW_POS_EN
  logic [2:0]  pc1, pr1, pc2, pr2;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   cnt1 = 0, cnt2 = 0, lcnt1 = 0, lcnt2 = 0;
  int   mr = 0, mc = 0;
  int   img [8][8];
  exp_t q1[$];
  exp_t q2[$];

  localparam logic [71:0] FIRST_WIN = 72'h12_11_10_0A_09_08_02_01_00;
  localparam logic [71:0] LAST_S1   = 72'h3F_3E_3D_37_36_35_2F_2E_2D;
  localparam logic [71:0] LAST_S2   = 72'h36_35_34_2E_2D_2C_26_25_24;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sliding_window_kxk #(.DATA_WIDTH(8), .IMG_WIDTH(8), .IMG_HEIGHT(8), .K(3), .STRIDE(1)) dut1 (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .sof_in(sof_in),
    .window_out(w1), .valid_out(v1), .last_out(l1)
`ifdef SLIDING_WINDOW_POS_EN
    , .win_col_out(pc1), .win_row_out(pr1)
`endif
  );

  sliding_window_kxk #(.DATA_WIDTH(8), .IMG_WIDTH(8), .IMG_HEIGHT(8), .K(3), .STRIDE(2)) dut2 (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .sof_in(sof_in),
    .window_out(w2), .valid_out(v2), .last_out(l2)
`ifdef SLIDING_WINDOW_POS_EN
    , .win_col_out(pc2), .win_row_out(pr2)
`endif
  );

  function automatic logic [71:0] exp_win(int r, int c);
    logic [71:0] w;
    w = '0;
    for (int wr = 0; wr < 3; wr++)
      for (int wc = 0; wc < 3; wc++)
        w[(wr*3+wc)*8 +: 8] = 8'(img[r-2+wr][c-2+wc]);
    return w;
  endfunction

  // Drive one cycle; on an accepted pixel update the raster model and push expectations
  task automatic drive_px(input bit v, input bit s);
    exp_t e;
    @(negedge clk);
    valid_in = v;
    sof_in   = s;
    data_in  = 8'($urandom);
    if (v) begin
      if (s) begin mr = 0; mc = 0; end
      data_in = 8'(mr*8 + mc);
      img[mr][mc] = mr*8 + mc;
      if (mr >= 2 && mc >= 2) begin
        e.win  = exp_win(mr, mc);
        e.tag  = cyc + 1;
        e.pc   = mc - 2;
        e.pr   = mr - 2;
        e.last = (mr == 7 && mc == 7);
        q1.push_back(e);
        if ((mr - 2) % 2 == 0 && (mc - 2) % 2 == 0) begin
          e.pc   = (mc - 2) / 2;
          e.pr   = (mr - 2) / 2;
          e.last = (mr == 6 && mc == 6);
          q2.push_back(e);
        end
      end
      mc++;
      if (mc == 8) begin
        mc = 0;
        mr = (mr == 7) ? 0 : mr + 1;
      end
    end
  endtask

  // Scoreboard for the stride-1 instance
  always @(negedge clk) begin
    exp_t e;
    if (v1 === 1'b1) begin
      cnt1++;
      if (l1 === 1'b1) lcnt1++;
      n_checks++;
      if (q1.size() == 0 || q1[0].tag != cyc) begin
        n_fail++;
        $display("FAIL s1_unexpected_pulse cyc=%0d: got valid_out=1, expected no window", cyc);
      end else begin
        e = q1.pop_front();
        if (w1 !== e.win || l1 !== e.last) begin
          n_fail++;
          $display("FAIL s1_window cyc=%0d: got %h last=%b, expected %h last=%b", cyc, w1, l1, e.win, e.last);
        end
`ifdef SLIDING_WINDOW_POS_EN
        n_checks++;
        if (pc1 !== 3'(e.pc) || pr1 !== 3'(e.pr)) begin
          n_fail++;
          $display("FAIL s1_pos cyc=%0d: got (%0d,%0d), expected (%0d,%0d)", cyc, pc1, pr1, e.pc, e.pr);
        end
`endif
      end
    end else if (q1.size() != 0 && q1[0].tag <= cyc) begin
      e = q1.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL s1_missing_pulse cyc=%0d: got valid_out=%b, expected window %h", cyc, v1, e.win);
    end
  end

  // Scoreboard for the stride-2 instance
  always @(negedge clk) begin
    exp_t e;
    if (v2 === 1'b1) begin
      cnt2++;
      if (l2 === 1'b1) lcnt2++;
      n_checks++;
      if (q2.size() == 0 || q2[0].tag != cyc) begin
        n_fail++;
        $display("FAIL s2_unexpected_pulse cyc=%0d: got valid_out=1, expected no window", cyc);
      end else begin
        e = q2.pop_front();
        if (w2 !== e.win || l2 !== e.last) begin
          n_fail++;
          $display("FAIL s2_window cyc=%0d: got %h last=%b, expected %h last=%b", cyc, w2, l2, e.win, e.last);
        end
`ifdef SLIDING_WINDOW_POS_EN
        n_checks++;
        if (pc2 !== 3'(e.pc) || pr2 !== 3'(e.pr)) begin
          n_fail++;
          $display("FAIL s2_pos cyc=%0d: got (%0d,%0d), expected (%0d,%0d)", cyc, pc2, pr2, e.pc, e.pr);
        end
`endif
      end
    end else if (q2.size() != 0 && q2[0].tag <= cyc) begin
      e = q2.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL s2_missing_pulse cyc=%0d: got valid_out=%b, expected window %h", cyc, v2, e.win);
    end
  end

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b0; sof_in = 1'b0; data_in = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (v1 !== 1'b0 || l1 !== 1'b0 || w1 !== 72'h0 || v2 !== 1'b0 || l2 !== 1'b0 || w2 !== 72'h0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b%b l=%b%b w1=%h w2=%h, expected all zero", v1, v2, l1, l2, w1, w2);
    end
`ifdef SLIDING_WINDOW_POS_EN
    n_checks++;
    if (pc1 !== 3'd0 || pr1 !== 3'd0 || pc2 !== 3'd0 || pr2 !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_pos: got %0d %0d %0d %0d, expected 0", pc1, pr1, pc2, pr2);
    end
`endif
    rst = 1'b0;
    mr = 0; mc = 0;
  endtask

  task automatic test_clean_frame();
    int c1, c2, k1, k2;
    c1 = cnt1; c2 = cnt2; k1 = lcnt1; k2 = lcnt2;
    for (int i = 0; i < 64; i++) begin
      drive_px(1'b1, i == 0);
      if (i == 19) begin
        n_checks++;
        if (v1 !== 1'b1 || w1 !== FIRST_WIN) begin
          n_fail++;
          $display("FAIL first_window_latency: got v=%b w=%h, expected v=1 w=%h", v1, w1, FIRST_WIN);
        end
      end
      if (i == 55) begin
        n_checks++;
        if (v2 !== 1'b1 || l2 !== 1'b1 || w2 !== LAST_S2) begin
          n_fail++;
          $display("FAIL s2_last_at_px54: got v=%b l=%b w=%h, expected v=1 l=1 w=%h", v2, l2, w2, LAST_S2);
        end
      end
    end
    drive_px(1'b0, 1'b0);
    n_checks++;
    if (v1 !== 1'b1 || l1 !== 1'b1 || w1 !== LAST_S1 || v2 !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_end_px63: got v1=%b l1=%b w1=%h v2=%b, expected v1=1 l1=1 w1=%h v2=0", v1, l1, w1, v2, LAST_S1);
    end
    drive_px(1'b0, 1'b0);
    n_checks++;
    if (cnt1 - c1 != 36 || cnt2 - c2 != 9 || lcnt1 - k1 != 1 || lcnt2 - k2 != 1) begin
      n_fail++;
      $display("FAIL clean_counts: got s1=%0d s2=%0d last=%0d/%0d, expected 36 9 last=1/1",
               cnt1 - c1, cnt2 - c2, lcnt1 - k1, lcnt2 - k2);
    end
    n_checks++;
    if (w1 !== LAST_S1 || w2 !== LAST_S2) begin
      n_fail++;
      $display("FAIL window_hold: got %h %h, expected %h %h", w1, w2, LAST_S1, LAST_S2);
    end
  endtask

  task automatic test_random_gaps();
    int c1, c2, k1, k2, acc, it;
    bit v;
    c1 = cnt1; c2 = cnt2; k1 = lcnt1; k2 = lcnt2;
    acc = 0; it = 0;
    while (acc < 64 && it < 2000) begin
      v = 1'($urandom_range(0, 1));
      drive_px(v, !v && 1'($urandom_range(0, 1)));
      if (v) acc++;
      it++;
    end
    repeat (2) drive_px(1'b0, 1'b0);
    n_checks++;
    if (acc != 64) begin
      n_fail++;
      $display("FAIL random_budget: got %0d accepted pixels, expected 64", acc);
    end
    n_checks++;
    if (cnt1 - c1 != 36 || cnt2 - c2 != 9 || lcnt1 - k1 != 1 || lcnt2 - k2 != 1) begin
      n_fail++;
      $display("FAIL random_counts: got s1=%0d s2=%0d last=%0d/%0d, expected 36 9 last=1/1",
               cnt1 - c1, cnt2 - c2, lcnt1 - k1, lcnt2 - k2);
    end
  endtask

  task automatic test_sof_back_to_back();
    int c1, c2, k1, k2;
    c1 = cnt1; c2 = cnt2; k1 = lcnt1; k2 = lcnt2;
    for (int i = 0; i < 30; i++) drive_px(1'b1, 1'b0);
    drive_px(1'b1, 1'b1);
    for (int j = 1; j < 64; j++) begin
      drive_px(1'b1, 1'b0);
      if (j == 19) begin
        n_checks++;
        if (v1 !== 1'b1 || w1 !== FIRST_WIN || v2 !== 1'b1 || w2 !== FIRST_WIN) begin
          n_fail++;
          $display("FAIL sof_first_window: got v=%b%b w1=%h w2=%h, expected v=11 w=%h", v1, v2, w1, w2, FIRST_WIN);
        end
      end
    end
    for (int j = 0; j < 64; j++) drive_px(1'b1, 1'b0);
    repeat (2) drive_px(1'b0, 1'b0);
    n_checks++;
    if (cnt1 - c1 != 82 || cnt2 - c2 != 21 || lcnt1 - k1 != 2 || lcnt2 - k2 != 2) begin
      n_fail++;
      $display("FAIL sof_counts: got s1=%0d s2=%0d last=%0d/%0d, expected 82 21 last=2/2",
               cnt1 - c1, cnt2 - c2, lcnt1 - k1, lcnt2 - k2);
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 41; i++) drive_px(1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1; valid_in = 1'b0; sof_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mr = 0; mc = 0;
    n_checks++;
    if (v1 !== 1'b0 || l1 !== 1'b0 || v2 !== 1'b0 || l2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got v=%b%b l=%b%b, expected 0000", v1, v2, l1, l2);
    end
    for (int i = 0; i < 64; i++) begin
      drive_px(1'b1, 1'b0);
      if (i == 18) begin
        n_checks++;
        if (v1 !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_mid_early: got valid_out=%b after 18 pixels, expected 0", v1);
        end
      end
      if (i == 19) begin
        n_checks++;
        if (v1 !== 1'b1 || w1 !== FIRST_WIN) begin
          n_fail++;
          $display("FAIL reset_mid_first: got v=%b w=%h, expected v=1 w=%h", v1, w1, FIRST_WIN);
        end
      end
    end
    repeat (2) drive_px(1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_random_gaps();
    test_sof_back_to_back();
    test_reset_mid_frame();
    repeat (3) drive_px(1'b0, 1'b0);
    n_checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending windows, expected 0/0", q1.size(), q2.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
